// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential double-dabble binary-to-BCD converter, one bit per
//            clock, with registered digit outputs and a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_Start,
    input  logic [WIDTH-1:0] i_Bin,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Overflow,
    output logic [3:0]       o_Digit_1,
    output logic [3:0]       o_Digit_2,
    output logic [3:0]       o_Digit_3,
    output logic [3:0]       o_Digit_4
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] bin_q,      bin_d;
    logic [15:0]      scratch_q,  scratch_d;
    logic [4:0]       cnt_q,      cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [15:0]      digits_q,   digits_d;
    logic             overflow_q, overflow_d;

    logic [15:0]      adj;
    logic [31:0]      bin_ext;

    // Add-3 correction is applied per nibble with no carry between digits.
    genvar n;
    generate
        for (n = 0; n < 4; n++) begin : g_nibble
            assign adj[4*n +: 4] = (scratch_q[4*n +: 4] >= 4'd5)
                                 ? scratch_q[4*n +: 4] + 4'd3
                                 : scratch_q[4*n +: 4];
        end
    endgenerate

    assign bin_ext = {{(32-WIDTH){1'b0}}, i_Bin};

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;

        case (state_q)
            c_IDLE: begin
                if (i_Start) begin
                    state_d    = c_SHIFT;
                    bin_d      = i_Bin;
                    scratch_d  = 16'd0;
                    cnt_d      = 5'(WIDTH);
                    ovf_pend_d = (bin_ext > 32'(MAX_VAL));
                end
            end
            c_SHIFT: begin
                scratch_d = {adj[14:0], bin_q[WIDTH-1]};
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q - 5'd1;
                // Digits are published only on the final iteration edge.
                if (cnt_q == 5'd1) begin
                    state_d = c_DONE;
                    if (ovf_pend_q) begin
                        digits_d   = 16'h9999;
                        overflow_d = 1'b1;
                    end else begin
                        digits_d   = {adj[14:0], bin_q[WIDTH-1]};
                        overflow_d = 1'b0;
                    end
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= c_IDLE;
            bin_q      <= '0;
            scratch_q  <= 16'd0;
            cnt_q      <= 5'd0;
            ovf_pend_q <= 1'b0;
            digits_q   <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_Busy     = (state_q == c_SHIFT);
    assign o_Done     = (state_q == c_DONE);
    assign o_Overflow = overflow_q;
    assign o_Digit_1  = digits_q[15:12];
    assign o_Digit_2  = digits_q[11:8];
    assign o_Digit_3  = digits_q[7:4];
    assign o_Digit_4  = digits_q[3:0];

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Directed self-checking bench for bin2bcd_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy, done, ovf;
    logic [3:0]  d1, d2, d3, d4;

    int n_checks;
    int n_errors;

    bin2bcd_seq #(.WIDTH(14), .MAX_VAL(9999)) dut (
        .i_CLK      (clk),
        .i_RST_N    (rst_n),
        .i_Start    (start),
        .i_Bin      (bin),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Overflow (ovf),
        .o_Digit_1  (d1),
        .o_Digit_2  (d2),
        .o_Digit_3  (d3),
        .o_Digit_4  (d4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {d1, d2, d3, d4};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full conversion: accept on E0, then expect o_Done exactly 14 edges later.
    task automatic run_conv(input logic [13:0] v, input logic [15:0] exp_dig,
                            input logic exp_ovf, input string tag);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 14);
        chk({tag, "_busy_cycles"}, busy_cnt, 14);
        chk({tag, "_digits"}, digits(), exp_dig);
        chk({tag, "_ovf"}, ovf, exp_ovf);
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, done, 0);
    endtask

    initial begin
        int d_first, d_second, done_seen;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_digits", digits(), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        run_conv(14'd1234, 16'h1234, 1'b0, "c1234");
        run_conv(14'd0,    16'h0000, 1'b0, "c0");
        run_conv(14'd9999, 16'h9999, 1'b0, "c9999");
        run_conv(14'd1000, 16'h1000, 1'b0, "c1000");
        run_conv(14'd7,    16'h0007, 1'b0, "c7");
        run_conv(14'd10000, 16'h9999, 1'b1, "c10000");
        run_conv(14'd16383, 16'h9999, 1'b1, "c16383");
        run_conv(14'd42,   16'h0042, 1'b0, "c42");

        // Start held high: back-to-back conversions, input changes mid-run ignored.
        @(negedge clk);
        bin   = 14'd5678;
        start = 1'b1;
        @(posedge clk); #1;
        d_first  = -1;
        d_second = -1;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            if (c == 3) bin = 14'd1111;
            if (c == 8) bin = 14'd3333;
            if (c == 15) chk("hold_idle_after_done", busy, 0);
            if (c == 16) chk("hold_reaccept", busy, 1);
            if (done && d_first < 0) begin
                d_first = c;
                chk("hold_first_digits", digits(), 16'h5678);
                bin = 14'd2468;
            end else if (done && d_second < 0) begin
                d_second = c;
                chk("hold_second_digits", digits(), 16'h2468);
                start = 1'b0;
            end
        end
        chk("hold_first_latency", d_first, 14);
        chk("hold_done_period", d_second - d_first, 16);
        chk("hold_idle_end", busy, 0);

        // Reset mid-conversion.
        run_conv(14'd4321, 16'h4321, 1'b0, "c4321");
        @(negedge clk);
        bin   = 14'd8765;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_digits", digits(), 16'h0000);
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(14'd8765, 16'h8765, 1'b0, "c8765");

        // Digit stability across a conversion.
        run_conv(14'd1111, 16'h1111, 1'b0, "c1111");
        @(negedge clk);
        bin   = 14'd2222;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            chk($sformatf("stable_c%0d", c), digits(), (c < 14) ? 16'h1111 : 16'h2222);
            @(negedge clk);
            chk($sformatf("stable_neg_c%0d", c), digits(), (c < 14) ? 16'h1111 : 16'h2222);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
